// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - four-requester arbiter driving a shared 32-bit 4:1 data mux
//
// Purpose: grants one of four requesters per tenure, captures the owner's data word
// each cycle it keeps requesting, and hands over at the tenure end with no idle gap.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - synchronous, active-high
//   req[3:0]   - request lines, bit i belongs to requester i
//   in1..in4   - 32-bit data words of requesters 0..3
//   grant[3:0] - registered one-hot grant, zero when idle
//   select     - registered index of the current owner (shared mux select)
//   out        - registered data word captured from the owner
//   out_valid  - registered, high for one cycle per captured word
//
// Parameter: MAX_HOLD (1..255) - maximum consecutive grant cycles per tenure.
// Compile-time option: RR_ARB_FIXED_PRIORITY_EN - when defined, the lowest-index
// requester always wins instead of round-robin.

module rr_mux_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [31:0] in3,
    input  logic [31:0] in4,
    output logic [3:0]  grant,
    output logic [1:0]  select,
    output logic [31:0] out,
    output logic        out_valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t      state_q;
    logic [3:0]  grant_q;
    logic [1:0]  select_q;
    logic [31:0] out_q;
    logic        out_valid_q;
    logic [7:0]  hold_cnt_q;
    logic [1:0]  last_owner_q;

    logic [31:0] mux_data_d;
    logic [1:0]  win_d;
    logic        any_req_d;
    logic        owner_req_d;
    logic        tenure_end_d;

    // Shared 4:1 data mux steered by the registered owner index.
    always_comb begin
        mux_data_d = in1;
        case (select_q)
            2'd0: mux_data_d = in1;
            2'd1: mux_data_d = in2;
            2'd2: mux_data_d = in3;
            2'd3: mux_data_d = in4;
            default: mux_data_d = in1;
        endcase
    end

    // Winner selection. In round-robin mode the search starts just past the last
    // owner, so the current owner is only reached when nobody else is requesting;
    // that gives the owner exclusion on handover for free.
    always_comb begin
        logic [1:0] idx;
        win_d = 2'd0;
        idx   = 2'd0;
`ifdef RR_ARB_FIXED_PRIORITY_EN
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) begin
                win_d = 2'(i);
            end
        end
`else
        // Walk from farthest to nearest so the nearest requester is written last.
        for (int k = 4; k >= 1; k--) begin
            idx = last_owner_q + 2'(k);
            if (req[idx]) begin
                win_d = idx;
            end
        end
`endif
    end

    always_comb begin
        any_req_d    = |req;
        owner_req_d  = req[select_q];
        tenure_end_d = !owner_req_d || (hold_cnt_q == HOLD_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 4'b0000;
            select_q     <= 2'd0;
            out_q        <= 32'd0;
            out_valid_q  <= 1'b0;
            hold_cnt_q   <= 8'd0;
            last_owner_q <= 2'd3;
        end else begin
            case (state_q)
                IDLE: begin
                    out_valid_q <= 1'b0;
                    if (any_req_d) begin
                        state_q      <= GRANT;
                        grant_q      <= 4'b0001 << win_d;
                        select_q     <= win_d;
                        last_owner_q <= win_d;
                        hold_cnt_q   <= 8'd0;
                    end
                end
                GRANT: begin
                    if (owner_req_d) begin
                        out_q       <= mux_data_d;
                        out_valid_q <= 1'b1;
                        hold_cnt_q  <= hold_cnt_q + 8'd1;
                    end else begin
                        out_valid_q <= 1'b0;
                    end
                    // Handover overrides the counter increment above.
                    if (tenure_end_d) begin
                        hold_cnt_q <= 8'd0;
                        if (any_req_d) begin
                            grant_q      <= 4'b0001 << win_d;
                            select_q     <= win_d;
                            last_owner_q <= win_d;
                        end else begin
                            state_q <= IDLE;
                            grant_q <= 4'b0000;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 4'b0000;
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign select    = select_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - self-checking bench for rr_mux_arbiter

module tb_rr_mux_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [31:0] in1 = 32'd0;
    logic [31:0] in2 = 32'd0;
    logic [31:0] in3 = 32'd0;
    logic [31:0] in4 = 32'd0;

    logic [3:0]  g8, g2, g1;
    logic [1:0]  s8, s2, s1;
    logic [31:0] o8, o2, o1;
    logic        v8, v2, v1;

    logic [3:0]  ga [3];
    logic [1:0]  sa [3];
    logic [31:0] oa [3];
    logic        va [3];

    int checks = 0;
    int passes = 0;
    int prints = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.MAX_HOLD(8)) u8 (
        .clk(clk), .reset(reset), .req(req),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .grant(g8), .select(s8), .out(o8), .out_valid(v8)
    );
    rr_mux_arbiter #(.MAX_HOLD(2)) u2 (
        .clk(clk), .reset(reset), .req(req),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .grant(g2), .select(s2), .out(o2), .out_valid(v2)
    );
    rr_mux_arbiter #(.MAX_HOLD(1)) u1 (
        .clk(clk), .reset(reset), .req(req),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .grant(g1), .select(s1), .out(o1), .out_valid(v1)
    );

    assign ga[0] = g8; assign ga[1] = g2; assign ga[2] = g1;
    assign sa[0] = s8; assign sa[1] = s2; assign sa[2] = s1;
    assign oa[0] = o8; assign oa[1] = o2; assign oa[2] = o1;
    assign va[0] = v8; assign va[1] = v2; assign va[2] = v1;

    // Reference model: owner index (-1 when idle), words captured this tenure.
    int          holds [3] = '{8, 2, 1};
    int          m_owner [3];
    int          m_last [3];
    int          m_words [3];
    logic [31:0] m_out [3];
    logic        m_ov [3];

    function automatic int pick(input logic [3:0] r, input int last);
`ifdef RR_ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
`endif
        return -1;
    endfunction

    task automatic model_update();
        logic [31:0] d [4];
        bit ended;
        d[0] = in1; d[1] = in2; d[2] = in3; d[3] = in4;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                m_owner[i] = -1; m_last[i] = 3; m_words[i] = 0;
                m_out[i] = 32'd0; m_ov[i] = 1'b0;
            end else if (m_owner[i] < 0) begin
                m_ov[i] = 1'b0;
                if (req != 4'b0000) begin
                    m_owner[i] = pick(req, m_last[i]);
                    m_last[i] = m_owner[i];
                    m_words[i] = 0;
                end
            end else begin
                if (req[m_owner[i]]) begin
                    m_out[i] = d[m_owner[i]];
                    m_ov[i] = 1'b1;
                    m_words[i]++;
                    ended = (m_words[i] == holds[i]);
                end else begin
                    m_ov[i] = 1'b0;
                    ended = 1'b1;
                end
                if (ended) begin
                    m_owner[i] = (req == 4'b0000) ? -1 : pick(req, m_owner[i]);
                    if (m_owner[i] >= 0) m_last[i] = m_owner[i];
                    m_words[i] = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 4'b1111;
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ga[i] !== 4'b0000 || sa[i] !== 2'd0 || oa[i] !== 32'd0 || va[i] !== 1'b0)
                $display("FAIL reset_state[%0d]: got g=%b s=%0d o=%h v=%b want 0000/0/0/0", i, ga[i], sa[i], oa[i], va[i]);
            else passes++;
        end
        reset = 1'b0;
        step();
        checks++;
        if (g8 !== 4'b0001) $display("FAIL reset_first_prio: got %b want 0001", g8);
        else passes++;
    endtask

    task automatic test_single_hold();
        reset = 1'b1; step(); reset = 1'b0;
        req = 4'b0001; in1 = 32'hAAAAAAAA;
        step();
        checks++;
        if (g8 !== 4'b0001 || v8 !== 1'b0) $display("FAIL hold_first_grant: got g=%b v=%b want 0001/0", g8, v8);
        else passes++;
        for (int w = 1; w <= 8; w++) begin
            step();
            checks++;
            if (v8 !== 1'b1 || o8 !== 32'hAAAAAAAA || g8 !== 4'b0001)
                $display("FAIL hold_word%0d: got g=%b o=%h v=%b want 0001/aaaaaaaa/1", w, g8, o8, v8);
            else passes++;
            checks++;
            if (u8.hold_cnt_q !== ((w == 8) ? 8'd0 : 8'(w)))
                $display("FAIL hold_cnt%0d: got %0d want %0d", w, u8.hold_cnt_q, (w == 8) ? 0 : w);
            else passes++;
        end
    endtask

    task automatic test_all_req();
        int eo, eo1, prev;
        reset = 1'b1; step(); reset = 1'b0;
        in1 = 32'h00000000; in2 = 32'h11111111; in3 = 32'h22222222; in4 = 32'h33333333;
        req = 4'b1111;
        prev = -1;
        for (int k = 0; k < 9; k++) begin
            step();
`ifdef RR_ARB_FIXED_PRIORITY_EN
            eo = 0; eo1 = 0;
`else
            eo = (k / 2) % 4; eo1 = k % 4;
`endif
            checks++;
            if (g2 !== (4'b0001 << eo) || s2 !== 2'(eo))
                $display("FAIL rr2_grant%0d: got g=%b s=%0d want %b/%0d", k, g2, s2, 4'b0001 << eo, eo);
            else passes++;
            checks++;
            if (g1 !== (4'b0001 << eo1)) $display("FAIL rr1_grant%0d: got %b want %b", k, g1, 4'b0001 << eo1);
            else passes++;
            if (k > 0) begin
                checks++;
                if (v2 !== 1'b1 || o2 !== 32'h11111111 * prev)
                    $display("FAIL rr2_out%0d: got o=%h v=%b want %h/1", k, o2, v2, 32'h11111111 * prev);
                else passes++;
            end
            prev = eo;
        end
`ifdef RR_ARB_FIXED_PRIORITY_EN
        req = 4'b1110;
        step();
        checks++;
        if (g2 !== 4'b0010) $display("FAIL fixed_drop0: got %b want 0010", g2);
        else passes++;
`endif
    endtask

    task automatic test_drop_owner();
        reset = 1'b1; step(); reset = 1'b0;
        req = 4'b0010; in2 = 32'hB0B0B0B0;
        step();
        checks++;
        if (g8 !== 4'b0010 || s8 !== 2'd1) $display("FAIL drop_grant: got g=%b s=%0d want 0010/1", g8, s8);
        else passes++;
        step(); step();
        checks++;
        if (v8 !== 1'b1 || o8 !== 32'hB0B0B0B0) $display("FAIL drop_capture: got o=%h v=%b want b0b0b0b0/1", o8, v8);
        else passes++;
        in2 = 32'hDEAD0002; req = 4'b0101;
        step();
        checks++;
        if (v8 !== 1'b0 || o8 !== 32'hB0B0B0B0) $display("FAIL drop_nocapture: got o=%h v=%b want b0b0b0b0/0", o8, v8);
        else passes++;
        checks++;
`ifdef RR_ARB_FIXED_PRIORITY_EN
        if (g8 !== 4'b0001) $display("FAIL drop_next: got %b want 0001", g8);
`else
        if (g8 !== 4'b0100) $display("FAIL drop_next: got %b want 0100", g8);
`endif
        else passes++;
    endtask

    task automatic test_mid_reset();
        reset = 1'b1; step(); reset = 1'b0;
        req = 4'b0100; in3 = 32'hC3C3C3C3;
        step(); step();
        checks++;
        if (g8 !== 4'b0100 || o8 !== 32'hC3C3C3C3) $display("FAIL midrst_pre: got g=%b o=%h want 0100/c3c3c3c3", g8, o8);
        else passes++;
        reset = 1'b1; req = 4'b1111;
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ga[i] !== 4'b0000 || sa[i] !== 2'd0 || oa[i] !== 32'd0 || va[i] !== 1'b0)
                $display("FAIL midrst_clear[%0d]: got g=%b s=%0d o=%h v=%b want 0000/0/0/0", i, ga[i], sa[i], oa[i], va[i]);
            else passes++;
        end
        reset = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ga[i] !== 4'b0001) $display("FAIL midrst_first[%0d]: got %b want 0001", i, ga[i]);
            else passes++;
        end
    endtask

    task automatic test_idle();
        reset = 1'b1; step(); reset = 1'b0;
        req = 4'b0000;
        for (int c = 0; c < 20; c++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ga[i] !== 4'b0000 || va[i] !== 1'b0)
                    $display("FAIL idle%0d[%0d]: got g=%b v=%b want 0000/0", c, i, ga[i], va[i]);
                else passes++;
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] eg;
        reset = 1'b1; step(); reset = 1'b0;
        for (int c = 0; c < 400; c++) begin
            req   = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom);
            in1   = $urandom; in2 = $urandom; in3 = $urandom; in4 = $urandom;
            reset = ($urandom_range(0, 59) == 0);
            step();
            for (int i = 0; i < 3; i++) begin
                eg = (m_owner[i] < 0) ? 4'b0000 : (4'b0001 << m_owner[i]);
                checks++;
                if (ga[i] !== eg || va[i] !== m_ov[i] || oa[i] !== m_out[i] ||
                    (m_owner[i] >= 0 && sa[i] !== 2'(m_owner[i]))) begin
                    if (prints < 30)
                        $display("FAIL random%0d[%0d]: got g=%b s=%0d o=%h v=%b want g=%b o=%h v=%b",
                                 c, i, ga[i], sa[i], oa[i], va[i], eg, m_out[i], m_ov[i]);
                    prints++;
                end else passes++;
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_hold();
        test_all_req();
        test_drop_owner();
        test_mid_reset();
        test_idle();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, sets the maximum consecutive grant cycles per tenure; legal range is 1..255.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  4  request lines; req[i] belongs to requester i (0..3).
REQ-005 in1, in2, in3, in4  input  32 each  data words from requesters 0, 1, 2, 3 respectively.
REQ-006 grant  output  4  registered one-hot grant, or all-zero when idle.
REQ-007 select  output  2  registered binary index of the current owner; drives the shared 4:1 32-bit mux select.
REQ-008 out  output  32  registered data word captured from the owner.
REQ-009 out_valid  output  1  registered; high for one cycle per captured word.

Function
REQ-010 The block SHALL implement a two-state FSM with states IDLE and GRANT.
REQ-011 In IDLE with req==0, the block SHALL stay in IDLE, keep grant=0, and clear out_valid.
REQ-012 In IDLE with req!=0, the block SHALL arbitrate at the clock edge and be in GRANT with grant one-hot and select set on the next cycle.
REQ-013 Arbitration SHALL be round-robin: the search starts at (last_owner+1) mod 4 and wraps; the first requester with req high wins.
REQ-014 On each edge in GRANT where req[select]=1, the block SHALL load out with the selected input, set out_valid=1, and increment hold_cnt; otherwise it SHALL clear out_valid and hold out.
REQ-015 A tenure SHALL end at the edge where req[select]=0, or where req[select]=1 and hold_cnt==MAX_HOLD-1; in the second case that edge's word is still captured.
REQ-016 At the end of a tenure, the block SHALL re-arbitrate in the same edge with no idle gap, excluding the current owner unless it is the only requester with req still high.
REQ-017 If no requester is eligible at the end of a tenure, the block SHALL go to IDLE and clear grant.
REQ-018 hold_cnt SHALL clear to 0 whenever a new grant is issued, including a re-grant to the same owner.
REQ-019 last_owner SHALL update to the winner on every grant.
REQ-020 grant SHALL never have more than one bit set, and select SHALL always equal the index of the set grant bit while in GRANT.
REQ-021 With MAX_HOLD=1, every tenure SHALL be exactly one cycle, and the grant SHALL rotate on every edge while at least two requesters are active.

Reset
REQ-022 When reset=1 at a clock edge, the block SHALL override all other activity, including mid-tenure.
REQ-023 After reset, state SHALL be IDLE, grant=0000, select=00, out=0, out_valid=0, hold_cnt=0, and last_owner=3, so requester 0 has first priority.

Configuration
REQ-024 Macro RR_ARB_FIXED_PRIORITY_EN SHALL select the arbitration policy at compile time.
REQ-025 With RR_ARB_FIXED_PRIORITY_EN defined, the lowest-index requester with req high SHALL always win, and the owner exclusion of REQ-016 SHALL NOT apply; all other rules, including MAX_HOLD, are unchanged.
REQ-026 Without RR_ARB_FIXED_PRIORITY_EN, round-robin per REQ-013 and REQ-016 SHALL apply.

Verification
REQ-027 Scenario 1: reset, then req=0001 held, in1=AAAAAAAA, MAX_HOLD=8 -> grant=0001 one cycle after req; out=AAAAAAAA with out_valid=1 from the next cycle; 8 words captured, then grant=0001 re-issued with hold_cnt=0.
REQ-028 Scenario 2: req=1111 held, MAX_HOLD=2, in1..in4=00000000/11111111/22222222/33333333 -> grant sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001; out follows one cycle behind with no out_valid gap.
REQ-029 Scenario 3: owner 1 holding, req[1] drops at cycle 3 of tenure while req=0101 -> at that edge out_valid=0 and no capture; next cycle grant=0100 (round-robin from 2).
REQ-030 Scenario 4: reset asserted mid-tenure with grant=0100 -> next cycle grant=0000, select=00, out=0, out_valid=0; with req=1111 afterwards, first grant=0001.
REQ-031 Scenario 5: RR_ARB_FIXED_PRIORITY_EN defined, req=1111, MAX_HOLD=2 -> grant stays 0001 on every tenure; drop req[0] -> next tenure grant=0010.
REQ-032 Scenario 6: req=0000 throughout after reset -> grant=0000 and out_valid=0 for 20 cycles.
